traffic_conflict_monitor: RTL and testbench

Independent safety monitor on the receiving end of the highway/side-road traffic-light controller's six lamp outputs. It samples the lamp drives each clock, checks that both approaches always show one legal aspect, never show conflicting aspects, and step through the mandated green→yellow→red→green order with correct durations. On any violation it latches a coded fault and drives a flash enable that forces all-red flashing downstream until an operator clear is accepted.

---
 rtl/traffic_conflict_monitor.sv | 100 ++++++++++
 tb/tb_traffic_conflict_monitor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: safety monitor latching lamp conflict/sequence/timing faults and driving all-red flash
module traffic_conflict_monitor #(
  parameter int YEL_MIN   = 5,
  parameter int SG_MAX    = 10,
  parameter int FLASH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hwr,
  input  logic       hwy,
  input  logic       hwg,
  input  logic       swr,
  input  logic       swy,
  input  logic       swg,
  input  logic       clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash,
  output logic       ok
);
  typedef enum logic [1:0] {A_R, A_Y, A_G, A_X} asp_t;
  typedef enum logic {MONITOR, FAULT} state_t;
  localparam logic [7:0] YM = 8'(YEL_MIN);
  localparam logic [7:0] SM = 8'(SG_MAX);
  localparam logic [7:0] FD = 8'(FLASH_DIV - 1);
  function automatic asp_t dec(input logic r, input logic y, input logic g);
    return ({r, y, g} == 3'b100) ? A_R : ({r, y, g} == 3'b010) ? A_Y : ({r, y, g} == 3'b001) ? A_G : A_X;
  endfunction
  function automatic logic bad_step(input asp_t p, input asp_t c);
    return c != A_X && c != p && !((p == A_G && c == A_Y) || (p == A_Y && c == A_R) || (p == A_R && c == A_G));
  endfunction
  function automatic logic [7:0] sat(input logic [7:0] x);
    return (x == 8'hff) ? x : x + 8'd1;
  endfunction
  state_t state, state_n;
  asp_t hw_a, sw_a, hw_p, sw_p;
  logic [7:0] hy_cnt, sy_cnt, sg_cnt, div;
  logic c1, c2, c3, c4, c5, clr_ok;
  logic [2:0] code;
  assign hw_a = dec(hwr, hwy, hwg);
  assign sw_a = dec(swr, swy, swg);
  // Per-sample rule checks; a lit yellow or green lamp makes an approach non-red even when the decode is illegal
  always_comb begin
    c1 = (hwy | hwg) & (swy | swg);
    c2 = hw_a == A_X || sw_a == A_X;
    c3 = bad_step(hw_p, hw_a) || bad_step(sw_p, sw_a);
    c4 = (hw_p == A_Y && hw_a == A_R && hy_cnt < YM) || (sw_p == A_Y && sw_a == A_R && sy_cnt < YM);
    c5 = sw_a == A_G && sg_cnt >= SM;
    code = c1 ? 3'd1 : c2 ? 3'd2 : c3 ? 3'd3 : c4 ? 3'd4 : c5 ? 3'd5 : 3'd0;
  end
  // Next state: first violation latches, a clear only counts when the lamps are legal and conflict-free
  always_comb begin
    state_n = state;
    clr_ok = state == FAULT && clr && !c1 && !c2;
    if (state == MONITOR && code != 3'd0) state_n = FAULT;
    if (clr_ok) state_n = MONITOR;
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= MONITOR;
    else state <= state_n;
  // Fault code, flash divider, run counters and previous aspects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_code <= 3'd0;
      flash <= 1'b0;
      div <= 8'd0;
      hy_cnt <= 8'd0;
      sy_cnt <= 8'd0;
      sg_cnt <= 8'd0;
      hw_p <= A_G;
      sw_p <= A_R;
    end else if (state == MONITOR) begin
      if (code != 3'd0) begin
        fault_code <= code;
        flash <= 1'b1;
      end
      div <= 8'd0;
      hy_cnt <= (hw_a == A_Y) ? sat(hy_cnt) : 8'd0;
      sy_cnt <= (sw_a == A_Y) ? sat(sy_cnt) : 8'd0;
      sg_cnt <= (sw_a == A_G) ? sat(sg_cnt) : 8'd0;
      if (hw_a != A_X) hw_p <= hw_a;
      if (sw_a != A_X) sw_p <= sw_a;
    end else if (clr_ok) begin
      fault_code <= 3'd0;
      flash <= 1'b0;
      div <= 8'd0;
      hy_cnt <= 8'd0;
      sy_cnt <= 8'd0;
      sg_cnt <= 8'd0;
      hw_p <= hw_a;
      sw_p <= sw_a;
    end else begin
      div <= (div == FD) ? 8'd0 : div + 8'd1;
      flash <= (div == FD) ? ~flash : flash;
    end
  end
  assign fault = state == FAULT;
  assign ok = state == MONITOR && code == 3'd0;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: directed checks of the traffic conflict monitor
module tb_traffic_conflict_monitor;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic hwr, hwy, hwg, swr, swy, swg;
  logic fault, flash, ok, ok_pre;
  logic [2:0] fault_code;
  int checks = 0, errors = 0, good = 0;
  localparam logic [5:0] HG_SR = 6'b001_100;
  localparam logic [5:0] HY_SR = 6'b010_100;
  localparam logic [5:0] HR_SG = 6'b100_001;
  localparam logic [5:0] HR_SY = 6'b100_010;
  traffic_conflict_monitor #(.YEL_MIN(5), .SG_MAX(10), .FLASH_DIV(4)) dut (
    .clk(clk), .rst(rst), .hwr(hwr), .hwy(hwy), .hwg(hwg), .swr(swr), .swy(swy), .swg(swg),
    .clr(clr), .fault(fault), .fault_code(fault_code), .flash(flash), .ok(ok)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [5:0] l, input logic c);
    @(negedge clk);
    {hwr, hwy, hwg, swr, swy, swg} = l;
    clr = c;
    #1 ok_pre = ok;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(l, 1'b0);
      if (ok_pre === 1'b1 && fault === 1'b0) good++;
    end
  endtask
  initial begin
    {hwr, hwy, hwg, swr, swy, swg} = HG_SR;
    #3;
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_flash", flash, 0);
    chk("rst_ok", ok, 1);
    @(negedge clk) rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      run(HG_SR, 3);
      run(HY_SR, 5);
      run(HR_SG, 10);
      run(HR_SY, 5);
    end
    chk("legal_good_cycles", 8'(good), 46);
    cyc(HG_SR, 1'b0);
    chk("legal_back_to_g", fault, 0);
    run(HY_SR, 4);
    cyc(HR_SG, 1'b0);
    chk("short_y_okpre", ok_pre, 0);
    chk("short_y_fault", fault, 1);
    chk("short_y_code", fault_code, 4);
    chk("short_y_flash", flash, 1);
    chk("fault_ok_low", ok, 0);
    cyc(6'b000_000, 1'b1);
    chk("clr_illegal_fault", fault, 1);
    chk("clr_illegal_code", fault_code, 4);
    cyc(HG_SR, 1'b1);
    chk("clr_fault", fault, 0);
    chk("clr_code", fault_code, 0);
    chk("clr_flash", flash, 0);
    cyc(HG_SR, 1'b1);
    chk("clr_in_monitor", fault, 0);
    run(HY_SR, 5);
    cyc(HR_SG, 1'b0);
    chk("yel5_legal", fault, 0);
    run(HR_SG, 9);
    cyc(HR_SY, 1'b0);
    chk("sg10_legal", fault, 0);
    run(HR_SY, 4);
    cyc(HG_SR, 1'b0);
    chk("side_y5_legal", fault, 0);
    run(HY_SR, 5);
    run(HR_SG, 10);
    chk("sg10_no_fault", fault, 0);
    cyc(HR_SG, 1'b0);
    chk("sg11_code", fault_code, 5);
    cyc(HG_SR, 1'b1);
    chk("sg_clr", fault, 0);
    cyc(6'b001_001, 1'b0);
    chk("conflict_code", fault_code, 1);
    chk("conflict_flash", flash, 1);
    run(HG_SR, 3);
    chk("flash_hold", flash, 1);
    cyc(HG_SR, 1'b0);
    chk("flash_toggle0", flash, 0);
    run(6'b000_000, 4);
    chk("flash_toggle1", flash, 1);
    chk("conflict_code_frozen", fault_code, 1);
    cyc(HG_SR, 1'b1);
    chk("conflict_clr", fault, 0);
    cyc(6'b100_100, 1'b0);
    chk("sequence_code", fault_code, 3);
    cyc(HG_SR, 1'b1);
    cyc(6'b000_000, 1'b0);
    chk("lamp_code", fault_code, 2);
    cyc(HG_SR, 1'b1);
    chk("lamp_clr", fault, 0);
    cyc(6'b011_001, 1'b0);
    chk("priority_code", fault_code, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_fault", fault, 0);
    chk("async_rst_code", fault_code, 0);
    chk("async_rst_flash", flash, 0);
    chk("rst_ok_conflict", ok, 0);
    {hwr, hwy, hwg, swr, swy, swg} = HG_SR;
    #1;
    chk("rst_ok_legal", ok, 1);
    @(negedge clk) rst = 1'b0;
    cyc(HG_SR, 1'b0);
    chk("post_rst_fault", fault, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
